// File: rtl/l2_dr_arb_pkg.sv
// Shared types for the L2/L2TLB <-> directory arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Holds the request and snack payload structs, the nodeid parity constants
// that mark which requester an entry came from, and a helper that stamps
// that parity onto a request.
package l2_dr_arb_pkg;

    localparam int NODEID_W = 5;

    // nodeid[0] identifies the source side inside the directory's view.
    localparam logic NODEID_PAR_L2  = 1'b0;
    localparam logic NODEID_PAR_TLB = 1'b1;

    typedef enum logic {
        SRC_L2  = 1'b0,
        SRC_TLB = 1'b1
    } src_e;

    typedef struct packed {
        logic [NODEID_W-1:0] nodeid;
        logic [2:0]          cmd;
        logic [31:0]         paddr;
    } I_l2todr_req_type;

    typedef struct packed {
        logic [NODEID_W-1:0] nodeid;
        logic [2:0]          ack;
        logic [31:0]         paddr;
    } I_drtol2_snack_type;

    function automatic I_l2todr_req_type tag_req(input I_l2todr_req_type req,
                                                 input logic             par);
        I_l2todr_req_type r;
        r           = req;
        r.nodeid[0] = par;
        return r;
    endfunction

endpackage

// File: rtl/l2_dr_arb_fifo.sv
// Two-entry request FIFO; head is presented straight from the storage flops.
// Latency: a push into an empty FIFO is visible at the output the next cycle.
// Backpressure: in_retry only when full and the head is not leaving this cycle.
//
// Ports: clk, reset (async active-low), in_valid/in_retry/in_data (write side),
//        out_valid/out_retry/out_data (read side, towards the directory).
module l2_dr_arb_fifo
    import l2_dr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_retry,
    input  I_l2todr_req_type in_data,
    output logic             out_valid,
    input  logic             out_retry,
    output I_l2todr_req_type out_data
);

    I_l2todr_req_type mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & ~out_retry;
    // A full FIFO can still take a new entry when the head drains this cycle.
    assign in_retry  = (count == 2'd2) & ~pop;
    assign push      = in_valid & ~in_retry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/l2_dr_arb.sv
// Arbitrates L2 and L2TLB requests into one directory channel; routes snacks back.
// Latency: request to l2todr_req 1 cycle when the FIFO is empty; snack path is combinational.
// Backpressure: retry to the loser and to both sides when the 2-entry FIFO is full and not draining.
//
// Ports: clk, reset (async active-low); l2_req*/tlb_req* requesters;
//        l2todr_req* to directory; drtol2_snack* from directory;
//        l2_snack*/tlb_snack* snack destinations.
// Build option: define L2_DR_ARB_FIXED_PRIO_EN to give TLB strict priority
// instead of round-robin.
module l2_dr_arb
    import l2_dr_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,

    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  I_l2todr_req_type   l2_req,

    input  logic               tlb_req_valid,
    output logic               tlb_req_retry,
    input  I_l2todr_req_type   tlb_req,

    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output I_l2todr_req_type   l2todr_req,

    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  I_drtol2_snack_type drtol2_snack,

    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output I_drtol2_snack_type l2_snack,

    output logic               tlb_snack_valid,
    input  logic               tlb_snack_retry,
    output I_drtol2_snack_type tlb_snack
);

    logic             fifo_retry;
    logic             can_accept;
    logic             pick_tlb;
    logic             grant_l2;
    logic             grant_tlb;
    I_l2todr_req_type push_data;

    assign can_accept = ~fifo_retry;

`ifdef L2_DR_ARB_FIXED_PRIO_EN
    // TLB always wins a tie; L2 only goes when TLB is idle.
    assign pick_tlb = tlb_req_valid;
`else
    src_e rr_ptr;

    // TLB wins when it is alone, or when both are valid and it is TLB's turn.
    assign pick_tlb = tlb_req_valid & (~l2_req_valid | (rr_ptr == SRC_TLB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= SRC_L2;
        end else if (grant_l2) begin
            rr_ptr <= SRC_TLB;
        end else if (grant_tlb) begin
            rr_ptr <= SRC_L2;
        end
    end
`endif

    assign grant_tlb = can_accept & pick_tlb;
    assign grant_l2  = can_accept & l2_req_valid & ~pick_tlb;

    // A side is retried when it asks but loses, or when no slot is free at all.
    assign l2_req_retry  = fifo_retry | (l2_req_valid  & ~grant_l2);
    assign tlb_req_retry = fifo_retry | (tlb_req_valid & ~grant_tlb);

    assign push_data = grant_tlb ? tag_req(tlb_req, NODEID_PAR_TLB)
                                 : tag_req(l2_req,  NODEID_PAR_L2);

    l2_dr_arb_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (grant_l2 | grant_tlb),
        .in_retry  (fifo_retry),
        .in_data   (push_data),
        .out_valid (l2todr_req_valid),
        .out_retry (l2todr_req_retry),
        .out_data  (l2todr_req)
    );

    // Snack routing: nodeid parity selects the destination.
    assign l2_snack  = drtol2_snack;
    assign tlb_snack = drtol2_snack;

    always_comb begin
        l2_snack_valid     = 1'b0;
        tlb_snack_valid    = 1'b0;
        drtol2_snack_retry = l2_snack_retry;
        if (drtol2_snack.nodeid[0] == NODEID_PAR_TLB) begin
            tlb_snack_valid    = drtol2_snack_valid;
            drtol2_snack_retry = tlb_snack_retry;
        end else begin
            l2_snack_valid     = drtol2_snack_valid;
        end
    end

endmodule

// File: tb/tb_l2_dr_arb.sv
module tb_l2_dr_arb;
    import l2_dr_arb_pkg::*;

    logic               clk;
    logic               reset;
    logic               l2_req_valid;
    logic               l2_req_retry;
    I_l2todr_req_type   l2_req;
    logic               tlb_req_valid;
    logic               tlb_req_retry;
    I_l2todr_req_type   tlb_req;
    logic               l2todr_req_valid;
    logic               l2todr_req_retry;
    I_l2todr_req_type   l2todr_req;
    logic               drtol2_snack_valid;
    logic               drtol2_snack_retry;
    I_drtol2_snack_type drtol2_snack;
    logic               l2_snack_valid;
    logic               l2_snack_retry;
    I_drtol2_snack_type l2_snack;
    logic               tlb_snack_valid;
    logic               tlb_snack_retry;
    I_drtol2_snack_type tlb_snack;

    int checks;
    int failures;

    l2_dr_arb dut (
        .clk                (clk),
        .reset              (reset),
        .l2_req_valid       (l2_req_valid),
        .l2_req_retry       (l2_req_retry),
        .l2_req             (l2_req),
        .tlb_req_valid      (tlb_req_valid),
        .tlb_req_retry      (tlb_req_retry),
        .tlb_req            (tlb_req),
        .l2todr_req_valid   (l2todr_req_valid),
        .l2todr_req_retry   (l2todr_req_retry),
        .l2todr_req         (l2todr_req),
        .drtol2_snack_valid (drtol2_snack_valid),
        .drtol2_snack_retry (drtol2_snack_retry),
        .drtol2_snack       (drtol2_snack),
        .l2_snack_valid     (l2_snack_valid),
        .l2_snack_retry     (l2_snack_retry),
        .l2_snack           (l2_snack),
        .tlb_snack_valid    (tlb_snack_valid),
        .tlb_snack_retry    (tlb_snack_retry),
        .tlb_snack          (tlb_snack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic I_l2todr_req_type mk_req(input logic [4:0] n, input logic [31:0] a);
        I_l2todr_req_type r;
        r.nodeid = n;
        r.cmd    = 3'd2;
        r.paddr  = a;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        l2_req_valid       = 1'b0;
        tlb_req_valid      = 1'b0;
        l2_req             = '0;
        tlb_req            = '0;
        l2todr_req_retry   = 1'b0;
        drtol2_snack_valid = 1'b0;
        drtol2_snack       = '0;
        l2_snack_retry     = 1'b0;
        tlb_snack_retry    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        checks++;
        if (l2todr_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", l2todr_req_valid);
        end
        checks++;
        if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0) begin
            failures++;
            $display("FAIL reset_retries got=%b%b exp=00", l2_req_retry, tlb_req_retry);
        end
        checks++;
        if (l2_snack_valid !== 1'b0 || tlb_snack_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_snack_valid got=%b%b exp=00", l2_snack_valid, tlb_snack_valid);
        end
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    // L2 alone, nodeid 6: accepted one cycle, visible the next, then drained.
    task automatic test_single_l2();
        do_reset();
        for (int i = 0; i < 4; i++) next_cycle();
        l2_req_valid = 1'b1;
        l2_req       = mk_req(5'd6, 32'h0000_1000);
        @(negedge clk);
        checks++;
        if (l2_req_retry !== 1'b0 || l2todr_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_accept got retry=%b outv=%b exp retry=0 outv=0",
                     l2_req_retry, l2todr_req_valid);
        end
        next_cycle();
        l2_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (l2todr_req_valid !== 1'b1 || l2todr_req.nodeid !== 5'd6
            || l2todr_req.paddr !== 32'h0000_1000 || l2todr_req.cmd !== 3'd2) begin
            failures++;
            $display("FAIL single_out got v=%b nid=%0d pa=%h exp v=1 nid=6 pa=00001000",
                     l2todr_req_valid, l2todr_req.nodeid, l2todr_req.paddr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (l2todr_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got v=%b exp=0", l2todr_req_valid);
        end
        next_cycle();
    endtask

    // Both valid continuously: L2,TLB,L2,TLB with TLB nodeid 4 -> 5.
    task automatic test_rr();
        logic [4:0] exp_nid;
        do_reset();
        l2_req_valid  = 1'b1;
        tlb_req_valid = 1'b1;
        l2_req        = mk_req(5'd6, 32'h0000_2000);
        tlb_req       = mk_req(5'd4, 32'h0000_3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (l2_req_retry !== (i % 2 == 1) || tlb_req_retry !== (i % 2 == 0)) begin
                failures++;
                $display("FAIL rr_grant cyc=%0d got l2r=%b tlbr=%b exp l2r=%b tlbr=%b",
                         i, l2_req_retry, tlb_req_retry, (i % 2 == 1), (i % 2 == 0));
            end
            if (i >= 1) begin
                exp_nid = ((i - 1) % 2 == 1) ? 5'd5 : 5'd6;
                checks++;
                if (l2todr_req_valid !== 1'b1 || l2todr_req.nodeid !== exp_nid) begin
                    failures++;
                    $display("FAIL rr_order cyc=%0d got v=%b nid=%0d exp v=1 nid=%0d",
                             i, l2todr_req_valid, l2todr_req.nodeid, exp_nid);
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    // TLB strict priority: four TLB grants, L2 retried throughout.
    task automatic test_fixed_prio();
        do_reset();
        l2_req_valid  = 1'b1;
        tlb_req_valid = 1'b1;
        l2_req        = mk_req(5'd6, 32'h0000_2000);
        tlb_req       = mk_req(5'd4, 32'h0000_3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (l2_req_retry !== 1'b1 || tlb_req_retry !== 1'b0) begin
                    failures++;
                    $display("FAIL fixed_grant cyc=%0d got l2r=%b tlbr=%b exp l2r=1 tlbr=0",
                             i, l2_req_retry, tlb_req_retry);
                end
            end
            if (i >= 1) begin
                checks++;
                if (l2todr_req_valid !== 1'b1 || l2todr_req.nodeid !== 5'd5) begin
                    failures++;
                    $display("FAIL fixed_out cyc=%0d got v=%b nid=%0d exp v=1 nid=5",
                             i, l2todr_req_valid, l2todr_req.nodeid);
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    // Directory stalls 10 cycles: two entries taken, then both sides retried,
    // head held stable; after release the three accepted requests emerge in order.
    task automatic test_backpressure();
        logic [31:0] exp_pa [3];
        logic [4:0]  exp_nid [3];
        exp_pa[0] = 32'h0000_A000; exp_nid[0] = 5'd6;
        exp_pa[1] = 32'h0000_B000; exp_nid[1] = 5'd5;
        exp_pa[2] = 32'h0000_A001; exp_nid[2] = 5'd6;
        do_reset();
        l2todr_req_retry = 1'b1;
        l2_req_valid     = 1'b1;
        tlb_req_valid    = 1'b1;
        l2_req           = mk_req(5'd7, 32'h0000_A000);
        tlb_req          = mk_req(5'd4, 32'h0000_B000);
        @(negedge clk);
        checks++;
        if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b1) begin
            failures++;
            $display("FAIL bp_c0 got l2r=%b tlbr=%b exp l2r=0 tlbr=1", l2_req_retry, tlb_req_retry);
        end
        next_cycle();
        l2_req = mk_req(5'd7, 32'h0000_A001);
        @(negedge clk);
        checks++;
        if (l2_req_retry !== 1'b1 || tlb_req_retry !== 1'b0) begin
            failures++;
            $display("FAIL bp_c1 got l2r=%b tlbr=%b exp l2r=1 tlbr=0", l2_req_retry, tlb_req_retry);
        end
        next_cycle();
        tlb_req = mk_req(5'd4, 32'h0000_B001);
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (l2_req_retry !== 1'b1 || tlb_req_retry !== 1'b1) begin
                failures++;
                $display("FAIL bp_full cyc=%0d got l2r=%b tlbr=%b exp 1 1",
                         c, l2_req_retry, tlb_req_retry);
            end
            checks++;
            if (l2todr_req_valid !== 1'b1 || l2todr_req.paddr !== exp_pa[0]
                || l2todr_req.nodeid !== exp_nid[0]) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b nid=%0d pa=%h exp v=1 nid=6 pa=%h",
                         c, l2todr_req_valid, l2todr_req.nodeid, l2todr_req.paddr, exp_pa[0]);
            end
            next_cycle();
        end
        l2todr_req_retry = 1'b0;
        @(negedge clk);
        checks++;
        if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got l2r=%b tlbr=%b exp l2r=0 tlbr=1", l2_req_retry, tlb_req_retry);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (l2todr_req_valid !== 1'b1 || l2todr_req.paddr !== exp_pa[k]
                || l2todr_req.nodeid !== exp_nid[k]) begin
                failures++;
                $display("FAIL bp_drain idx=%0d got v=%b nid=%0d pa=%h exp v=1 nid=%0d pa=%h",
                         k, l2todr_req_valid, l2todr_req.nodeid, l2todr_req.paddr,
                         exp_nid[k], exp_pa[k]);
            end
            next_cycle();
            if (k == 0) begin
                l2_req_valid  = 1'b0;
                tlb_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (l2todr_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got v=%b exp=0", l2todr_req_valid);
        end
        next_cycle();
    endtask

    task automatic test_snack();
        idle_inputs();
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = '{nodeid: 5'd3, ack: 3'd5, paddr: 32'hCAFE_0040};
        tlb_snack_retry    = 1'b1;
        l2_snack_retry     = 1'b0;
        #1;
        checks++;
        if (tlb_snack_valid !== 1'b1 || l2_snack_valid !== 1'b0 || drtol2_snack_retry !== 1'b1) begin
            failures++;
            $display("FAIL snack_tlb got tv=%b lv=%b r=%b exp tv=1 lv=0 r=1",
                     tlb_snack_valid, l2_snack_valid, drtol2_snack_retry);
        end
        checks++;
        if (tlb_snack.paddr !== 32'hCAFE_0040 || tlb_snack.nodeid !== 5'd3 || tlb_snack.ack !== 3'd5) begin
            failures++;
            $display("FAIL snack_payload got nid=%0d ack=%0d pa=%h exp nid=3 ack=5 pa=cafe0040",
                     tlb_snack.nodeid, tlb_snack.ack, tlb_snack.paddr);
        end
        drtol2_snack = '{nodeid: 5'd2, ack: 3'd1, paddr: 32'h0000_0080};
        #1;
        checks++;
        if (l2_snack_valid !== 1'b1 || tlb_snack_valid !== 1'b0 || drtol2_snack_retry !== 1'b0
            || l2_snack.paddr !== 32'h0000_0080) begin
            failures++;
            $display("FAIL snack_l2 got lv=%b tv=%b r=%b pa=%h exp lv=1 tv=0 r=0 pa=00000080",
                     l2_snack_valid, tlb_snack_valid, drtol2_snack_retry, l2_snack.paddr);
        end
        l2_snack_retry  = 1'b1;
        tlb_snack_retry = 1'b0;
        #1;
        checks++;
        if (drtol2_snack_retry !== 1'b1) begin
            failures++;
            $display("FAIL snack_l2_retry got r=%b exp=1", drtol2_snack_retry);
        end
        idle_inputs();
        next_cycle();
    endtask

    // Reset asserted with two entries queued: output drops at once, nothing stale later.
    task automatic test_reset_mid();
        do_reset();
        l2todr_req_retry = 1'b1;
        l2_req_valid     = 1'b1;
        l2_req           = mk_req(5'd6, 32'h0000_C000);
        next_cycle();
        l2_req           = mk_req(5'd6, 32'h0000_C001);
        next_cycle();
        l2_req_valid     = 1'b0;
        @(negedge clk);
        checks++;
        if (l2todr_req_valid !== 1'b1 || l2_req_retry !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_full got v=%b l2r=%b exp v=1 l2r=1", l2todr_req_valid, l2_req_retry);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (l2todr_req_valid !== 1'b0 || l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got v=%b l2r=%b tlbr=%b exp 0 0 0",
                     l2todr_req_valid, l2_req_retry, tlb_req_retry);
        end
        l2todr_req_retry = 1'b0;
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checks++;
            if (l2todr_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale cyc=%0d got v=%b exp=0", i, l2todr_req_valid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_l2();
`ifdef L2_DR_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_rr();
        test_backpressure();
`endif
        test_snack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_dr_arb.md
L2_DR_ARB -- requirements
Module: l2_dr_arb

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-003 SHALL have: l2_req_valid  in  1;  l2_req_retry  out  1;  l2_req  in  I_l2todr_req_type  L2 cache request.
REQ-004 SHALL have: tlb_req_valid  in  1;  tlb_req_retry  out  1;  tlb_req  in  I_l2todr_req_type  L2TLB request.
REQ-005 SHALL have: l2todr_req_valid  out  1;  l2todr_req_retry  in  1;  l2todr_req  out  I_l2todr_req_type  to directory.
REQ-006 SHALL have: drtol2_snack_valid  in  1;  drtol2_snack_retry  out  1;  drtol2_snack  in  I_drtol2_snack_type.
REQ-007 SHALL have: l2_snack_valid/tlb_snack_valid  out  1;  l2_snack_retry/tlb_snack_retry  in  1;  l2_snack/tlb_snack  out  I_drtol2_snack_type.

Function
REQ-008 SHALL transfer on any channel only in a cycle where valid=1 and retry=0.
REQ-009 SHALL hold requests in a 2-entry output FIFO; FIFO head drives l2todr_req/l2todr_req_valid directly from flops.
REQ-010 SHALL grant at most one requester per cycle, only when FIFO count<2, or count==2 with head popping that cycle.
REQ-011 SHALL assert l2_req_retry/tlb_req_retry for every requester not granted in that cycle, including both when FIFO full and not popping.
REQ-012 SHALL use round-robin: 1-bit pointer (0=L2, 1=TLB); sole valid requester wins; both valid -> pointer side wins; pointer flips to the other side after each grant.
REQ-013 SHALL force nodeid[0]=0 on L2-sourced and nodeid[0]=1 on TLB-sourced entries; all other fields pass unmodified.
REQ-014 SHALL present a request accepted in cycle N on l2todr_req in cycle N+1 when FIFO was empty (1-cycle latency).
REQ-015 SHALL preserve grant order; push and pop in the same cycle keep count unchanged; read/write pointers wrap modulo 2.
REQ-016 SHALL route drtol2_snack combinationally: nodeid[0]=0 -> l2_snack, 1 -> tlb_snack; unselected valid=0.
REQ-017 SHALL drive drtol2_snack_retry equal to the selected destination's retry; payload passes unmodified.
REQ-018 SHALL hold l2todr_req stable while l2todr_req_valid=1 and l2todr_req_retry=1.

Reset
REQ-019 SHALL, on reset low: FIFO empty, pointers 0, RR pointer=0 (L2); l2todr_req_valid=0; l2_req_retry=tlb_req_retry=0 (FIFO empty); snack outputs follow REQ-016.
REQ-020 SHALL discard FIFO contents when reset asserts mid-operation; no request emitted until reset deasserts.

Configuration
REQ-021 SHALL, with L2_DR_ARB_FIXED_PRIO_EN defined, give TLB strict priority over L2 when both valid (RR pointer unused/constant).
REQ-022 SHALL, without L2_DR_ARB_FIXED_PRIO_EN, use the round-robin of REQ-012.

Structure
REQ-023 SHALL take I_l2todr_req_type and I_drtol2_snack_type from the shared package; nodeid parity constants (L2=0, TLB=1) SHALL live there.
REQ-024 SHALL implement the FIFO as sub-module l2_dr_arb_fifo (2 entries, valid/retry both sides).

Verification
REQ-025 L2 alone sends nodeid 6 at cycle 5, directory retry=0 -> l2todr_req_valid=1 at cycle 6, nodeid 6.
REQ-026 Both valid continuously, retry=0, reset RR -> output order L2,TLB,L2,TLB; TLB nodeid 4 emitted as 5.
REQ-027 Directory retry=1 for 10 cycles, both valid -> two entries accepted, then both input retries=1; after release, order preserved, none lost.
REQ-028 Snack nodeid 3, tlb_snack_retry=1 -> tlb_snack_valid=1, l2_snack_valid=0, drtol2_snack_retry=1; nodeid 2 -> L2 path.
REQ-029 Reset low with 2 FIFO entries -> l2todr_req_valid=0 same cycle; after release, no stale request emitted.
REQ-030 With L2_DR_ARB_FIXED_PRIO_EN, both valid 4 cycles -> 4 TLB grants, L2 retried throughout.
